// File: rtl/arb_mux_n.sv
// arb_mux_n: N-input arbitrating multiplexer feeding a single-entry output register.
// Each cycle one requesting channel is granted (round-robin or fixed priority) and
// its word is captured when the output register is empty or being drained.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   per-channel request
//   in_data    channel i word at [i*WIDTH +: WIDTH]
//   in_ready   one-hot (or zero) take strobe, combinational
//   out_valid  output register holds a word
//   out_data   captured word
//   out_sel    index of the channel that supplied out_data
//   out_ready  downstream consumes the word when out_valid && out_ready
module arb_mux_n #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned RR_MODE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    input  logic                    out_ready
);

    localparam int unsigned      LAST_CH     = NUM_CH - 1;
    localparam logic [SEL_W-1:0] LAST_IDX    = SEL_W'(LAST_CH);
    localparam bit               ROUND_ROBIN = (RR_MODE != 0);

    // Parameter sanity: channel count range and index width must cover all channels.
    if ((NUM_CH < 2) || (NUM_CH > 16) || ((1 << SEL_W) < NUM_CH)) begin : gBadParams
        $error("arb_mux_n: NUM_CH must be 2..16 and 2**SEL_W >= NUM_CH");
    end

    // Registered state
    logic                validQ;
    logic [WIDTH-1:0]    dataQ;
    logic [SEL_W-1:0]    selQ;
    logic [SEL_W-1:0]    ptrQ;

    // Next-state values
    logic                validD;
    logic [WIDTH-1:0]    dataD;
    logic [SEL_W-1:0]    selD;
    logic [SEL_W-1:0]    ptrD;

    // Arbitration / handshake
    logic                accept;
    logic                grantHit;
    logic [SEL_W-1:0]    grantIdx;
    logic [SEL_W-1:0]    candIdx;
    logic [SEL_W-1:0]    searchBase;
    logic                xfer;
    logic [WIDTH-1:0]    selData;

    // Modular channel index: base + off, wrapped into 0..NUM_CH-1 (off < NUM_CH).
    function automatic logic [SEL_W-1:0] wrapAdd(input logic [SEL_W-1:0] base,
                                                 input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_CH) begin
            sum = sum - NUM_CH;
        end
        return SEL_W'(sum);
    endfunction

    // Register can take a word when empty or when its current word leaves this cycle.
    assign accept = !validQ || out_ready;

    // Fixed priority is a round-robin search anchored at channel 0.
    assign searchBase = ROUND_ROBIN ? ptrQ : '0;

    // Grant search: first requester starting at searchBase, wrapping around.
    always_comb begin
        grantHit = 1'b0;
        grantIdx = '0;
        candIdx  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            candIdx = wrapAdd(searchBase, k);
            if (!grantHit && in_valid[candIdx]) begin
                grantHit = 1'b1;
                grantIdx = candIdx;
            end
        end
    end

    assign xfer = accept && grantHit && !rst;

    // Data mux for the granted channel.
    always_comb begin
        selData = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grantIdx == SEL_W'(i)) begin
                selData = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot take strobe back to the granted source.
    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (xfer && (grantIdx == SEL_W'(i))) begin
                in_ready[i] = 1'b1;
            end
        end
    end

    // Next-state: capture on transfer, clear valid on drain without refill.
    always_comb begin
        validD = validQ;
        dataD  = dataQ;
        selD   = selQ;
        ptrD   = ptrQ;
        if (xfer) begin
            validD = 1'b1;
            dataD  = selData;
            selD   = grantIdx;
            if (ROUND_ROBIN) begin
                // Pointer moves just past the winner so it gets lowest priority next.
                ptrD = (grantIdx == LAST_IDX) ? '0 : SEL_W'(grantIdx + SEL_W'(1));
            end
        end else if (out_ready) begin
            validD = 1'b0;
        end
    end

    // State register; reset discards any pending word.
    always_ff @(posedge clk) begin
        if (rst) begin
            validQ <= 1'b0;
            dataQ  <= '0;
            selQ   <= '0;
            ptrQ   <= '0;
        end else begin
            validQ <= validD;
            dataQ  <= dataD;
            selQ   <= selD;
            ptrQ   <= ptrD;
        end
    end

    assign out_valid = validQ;
    assign out_data  = dataQ;
    assign out_sel   = selQ;

endmodule

// File: doc/arb_mux_n.md
# arb_mux_n

Parametrised N-input, WIDTH-bit arbitrating multiplexer with a valid/ready handshake on every input and on the output. It is the sequential successor to the 2:1 `genericValue` select mux in the datapath. Each cycle it selects one requesting channel, using round-robin or fixed priority, and captures that channel's word in a single-entry output register. Its intended use is sharing one downstream port, such as the memory or register-file write port, between several pipeline sources.

## Interface
- WIDTH, 32, data width per channel
- NUM_CH, 4, number of input channels (2..16, need not be a power of two)
- SEL_W, 2, width of the channel index; must satisfy 2^SEL_W >= NUM_CH
- RR_MODE, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  NUM_CH  bit i set = channel i presents a word
- in_data  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  out  NUM_CH  one-hot or zero; bit i set = channel i's word is taken this cycle
- out_valid  out  1  output register holds a word
- out_data  out  WIDTH  registered selected word
- out_sel  out  SEL_W  index of the channel that supplied out_data
- out_ready  in  1  downstream consumes out_data when out_valid && out_ready

## Operation
- State:
  - output register (out_valid, out_data, out_sel)
  - priority pointer ptr (SEL_W bits, range 0..NUM_CH-1)
- Reset (rst=1 at an edge):
  - out_valid=0, out_data=0, out_sel=0, ptr=0
  - in_ready is forced to all-zero while rst is high
  - reset overrides any transfer in the same cycle
- accept = !out_valid || out_ready (the register is empty, or is being drained this cycle).
- Grant g, combinational:
  - RR_MODE=1: g is the first i with in_valid[i], searching ptr, ptr+1, … NUM_CH-1, 0, … ptr-1.
  - RR_MODE=0: g is the lowest i with in_valid[i]. ptr stays 0.
- Handshake outputs:
  - in_ready[g]=1 only when accept && in_valid[g] && !rst.
  - All other in_ready bits are 0.
- Transfer (in_ready[g]=1) at the edge:
  - out_data <= in_data[g]
  - out_sel <= g
  - out_valid <= 1
  - RR_MODE=1 only: ptr <= (g==NUM_CH-1) ? 0 : g+1
- Drain without refill (out_valid && out_ready && no in_valid): out_valid <= 0. out_data and out_sel hold their last values.
- Stall (out_valid && !out_ready):
  - out_valid, out_data and out_sel stay stable.
  - All in_ready bits are 0.
  - ptr does not change.
- No request (in_valid all zero): ptr unchanged, nothing captured.
- Simultaneous drain and refill: the new word replaces the old one in the same edge, with no bubble.
- in_ready depends combinationally on in_valid and out_ready. Sources must not make in_valid depend on in_ready.
- A source holds in_valid and in_data stable until it sees its in_ready. The block does not check this.

## Timing
- Latency: 1 cycle from the transfer edge to out_valid/out_data.
- Throughput: 1 word per cycle while out_ready=1 and any in_valid is set.
- Fairness (RR_MODE=1): a continuously requesting channel is granted within NUM_CH transfers.
- Reset mid-operation: a pending output word is discarded. out_valid=0 in the cycle after the reset edge.
- First accept after reset: possible on the first edge with rst=0.

## Test plan
- Reset: hold rst=1 with in_valid=4'b1111 and out_ready=1 -> in_ready=0 throughout; after release out_valid=0, out_data=0, out_sel=0.
- Round-robin sweep (NUM_CH=4, RR_MODE=1): in_valid=4'b1111, channel i data = 32'hA0+i, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles, out_data 32'hA0,A1,A2,A3,A0.
- Skip and wrap: ptr=3, in_valid=4'b0101 -> grant 0, ptr becomes 1; next cycle grant 2, ptr becomes 3.
- Backpressure: out_valid=1 holding 32'hA1, out_ready=0 for 3 cycles, in_valid=4'b1111 -> in_ready=0 and out_data=32'hA1 for all 3 cycles; on out_ready=1 the next word loads in the same edge.
- Fixed priority (RR_MODE=0): in_valid=4'b1010 for 3 cycles with out_ready=1 -> out_sel=1 every cycle; channel 3 is never granted.
- Non-power-of-two (NUM_CH=3, SEL_W=2): in_valid=3'b111 -> out_sel 0,1,2,0; ptr never equals 3.
